// File: rtl/bitstream_rx_pkg.sv
// Shared constants, FSM encodings and types for the bitstream byte receiver.
package bitstream_rx_pkg;

    // Datapath geometry
    localparam int BYTE_WIDTH   = 8;
    localparam int MAX_BYTES_IN = 5;
    localparam int FIFO_DEPTH   = 16;
    localparam int ADDR_WIDTH   = 4;

    // Byte-count encoding on in_flag_bitstream: 0..5 legal, 6 and 7 illegal
    localparam logic [2:0] CNT_NONE = 3'd0;
    localparam logic [2:0] CNT_MAX  = 3'd5;

    // Receiver FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;  // nothing accepted yet
    localparam logic [1:0] ST_STREAM = 2'd1;  // bytes flowing, end not seen
    localparam logic [1:0] ST_DRAIN  = 2'd2;  // end marked, emptying buffer
    localparam logic [1:0] ST_DONE   = 2'd3;  // final byte consumed

    // One cycle of encoder output, in_bit_1 in lane 0
    typedef logic [MAX_BYTES_IN-1:0][BYTE_WIDTH-1:0] byte_group_t;

    typedef struct packed {
        logic [2:0]  n;
        logic        last;
        byte_group_t bytes;
    } push_req_t;

    // Count values 6 and 7 carry no meaning and must be flagged
    function automatic logic cnt_legal(input logic [2:0] n);
        return n <= CNT_MAX;
    endfunction

endpackage

// File: rtl/mw_byte_fifo.sv
// Circular byte buffer: up to MAX_BYTES_IN writes per cycle, one read per
// cycle, first-word-fall-through head. The caller guarantees wr_n fits.
module mw_byte_fifo #(
    parameter int BYTE_WIDTH   = bitstream_rx_pkg::BYTE_WIDTH,
    parameter int MAX_BYTES_IN = bitstream_rx_pkg::MAX_BYTES_IN,
    parameter int FIFO_DEPTH   = bitstream_rx_pkg::FIFO_DEPTH,
    parameter int ADDR_WIDTH   = bitstream_rx_pkg::ADDR_WIDTH
) (
    input  logic                                    clock_gating_flag_first,
    input  logic                                    clock_gating_flag_first_rst,
    input  logic [2:0]                              wr_n,
    input  logic [MAX_BYTES_IN-1:0][BYTE_WIDTH-1:0] wr_data,
    input  logic                                    rd_en,
    output logic [BYTE_WIDTH-1:0]                   rd_data,
    output logic [ADDR_WIDTH-1:0]                   wr_ptr,
    output logic [ADDR_WIDTH-1:0]                   rd_ptr,
    output logic [ADDR_WIDTH:0]                     count
);
    import bitstream_rx_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;

    logic [BYTE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  rd_fire;

    // A read of an empty buffer is a no-op rather than a pointer slip
    assign rd_fire = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Lane i lands at wr_ptr+i; the address wraps on its own
    always_ff @(posedge clock_gating_flag_first) begin
        for (int i = 0; i < MAX_BYTES_IN; i++) begin
            if (i < int'(wr_n))
                mem[wr_ptr + ADDR_WIDTH'(i)] <= wr_data[i];
        end
    end

    // Pointers and occupancy; count uses the pre-pop value plus the net change
    always_ff @(posedge clock_gating_flag_first or posedge clock_gating_flag_first_rst) begin
        if (clock_gating_flag_first_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_n);
            rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_fire);
            count  <= count + CW'(wr_n) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/bitstream_byte_receiver.sv
// Far end of the encoder bitstream link: takes 0..5 bytes per cycle, buffers
// them and serialises one byte per cycle with end-of-stream marking.
module bitstream_byte_receiver #(
    parameter int BYTE_WIDTH   = bitstream_rx_pkg::BYTE_WIDTH,
    parameter int MAX_BYTES_IN = bitstream_rx_pkg::MAX_BYTES_IN,
    parameter int FIFO_DEPTH   = bitstream_rx_pkg::FIFO_DEPTH,
    parameter int ADDR_WIDTH   = bitstream_rx_pkg::ADDR_WIDTH
) (
    input  logic                  clock_gating_flag_first,
    input  logic                  clock_gating_flag_first_rst,
    input  logic [BYTE_WIDTH-1:0] in_bit_1,
    input  logic [BYTE_WIDTH-1:0] in_bit_2,
    input  logic [BYTE_WIDTH-1:0] in_bit_3,
    input  logic [BYTE_WIDTH-1:0] in_bit_4,
    input  logic [BYTE_WIDTH-1:0] in_bit_5,
    input  logic [2:0]            in_flag_bitstream,
    input  logic                  in_flag_last,
    output logic                  in_ready,
    output logic [BYTE_WIDTH-1:0] out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  err_overflow,
    output logic                  err_count,
    output logic                  done
);
    import bitstream_rx_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;

    logic [1:0]                              state;
    logic [MAX_BYTES_IN-1:0][BYTE_WIDTH-1:0] in_group;
    logic [ADDR_WIDTH-1:0]                   wr_ptr, rd_ptr, last_ptr;
    logic                                    last_valid;
    logic [CW-1:0]                           count, free, count_after_pop;
    logic [BYTE_WIDTH-1:0]                   head_byte;
    logic [2:0]                              wr_n;
    logic                                    active, cnt_ok, has_bytes, fits;
    logic                                    push_ok, drop_grp, pop;

    assign in_group = {in_bit_5, in_bit_4, in_bit_3, in_bit_2, in_bit_1};

    // Inputs only matter before the end of stream has been seen
    assign active    = (state == ST_IDLE) || (state == ST_STREAM);
    assign cnt_ok    = cnt_legal(in_flag_bitstream);
    assign has_bytes = in_flag_bitstream != CNT_NONE;

    // Space is judged on the pre-pop count, so a group never relies on the
    // byte leaving this same cycle
    assign free     = CW'(FIFO_DEPTH) - count;
    assign fits     = CW'(in_flag_bitstream) <= free;
    assign push_ok  = active && cnt_ok && has_bytes && fits;
    assign drop_grp = active && cnt_ok && has_bytes && !fits;
    assign wr_n     = push_ok ? in_flag_bitstream : CNT_NONE;

    assign in_ready   = free >= CW'(MAX_BYTES_IN);
    assign fill_level = count;

    // Output side: DONE hides anything left, empty head reads as zero
    assign out_valid = (count != '0) && (state != ST_DONE);
    assign pop       = out_valid && out_ready;
    assign out_byte  = out_valid ? head_byte : '0;
    assign out_last  = out_valid && last_valid && (rd_ptr == last_ptr);
    assign done      = state == ST_DONE;

    assign count_after_pop = count - CW'(pop);

    mw_byte_fifo #(
        .BYTE_WIDTH   (BYTE_WIDTH),
        .MAX_BYTES_IN (MAX_BYTES_IN),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_fifo (
        .clock_gating_flag_first     (clock_gating_flag_first),
        .clock_gating_flag_first_rst (clock_gating_flag_first_rst),
        .wr_n                        (wr_n),
        .wr_data                     (in_group),
        .rd_en                       (pop),
        .rd_data                     (head_byte),
        .wr_ptr                      (wr_ptr),
        .rd_ptr                      (rd_ptr),
        .count                       (count)
    );

    // Stream FSM and end-of-stream pointer. On a last cycle without new bytes
    // the newest stored byte becomes the final one; if nothing will remain
    // after this cycle's pop there is no byte left to mark, so finish at once.
    always_ff @(posedge clock_gating_flag_first or posedge clock_gating_flag_first_rst) begin
        if (clock_gating_flag_first_rst) begin
            state      <= ST_IDLE;
            last_ptr   <= '0;
            last_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (in_flag_last) begin
                        if (push_ok) begin
                            last_ptr   <= wr_ptr + ADDR_WIDTH'(in_flag_bitstream) - ADDR_WIDTH'(1);
                            last_valid <= 1'b1;
                            state      <= ST_DRAIN;
                        end else if (count_after_pop != '0) begin
                            last_ptr   <= wr_ptr - ADDR_WIDTH'(1);
                            last_valid <= 1'b1;
                            state      <= ST_DRAIN;
                        end else begin
                            state      <= ST_DONE;
                        end
                    end else if (push_ok) begin
                        state <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last)
                        state <= ST_DONE;
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

    // Sticky error flags, frozen once the stream has ended
    always_ff @(posedge clock_gating_flag_first or posedge clock_gating_flag_first_rst) begin
        if (clock_gating_flag_first_rst) begin
            err_overflow <= 1'b0;
            err_count    <= 1'b0;
        end else begin
            if (drop_grp)
                err_overflow <= 1'b1;
            if (active && !cnt_ok)
                err_count <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bitstream_byte_receiver.sv
// Directed bench for bitstream_byte_receiver: vector table plus a wrap run.
module tb_bitstream_byte_receiver;

    logic             clock_gating_flag_first;
    logic             clock_gating_flag_first_rst;
    logic [4:0][7:0]  grp;
    logic [2:0]       in_flag_bitstream;
    logic             in_flag_last;
    logic             in_ready;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [4:0]       fill_level;
    logic             err_overflow;
    logic             err_count;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    bitstream_byte_receiver dut (
        .clock_gating_flag_first     (clock_gating_flag_first),
        .clock_gating_flag_first_rst (clock_gating_flag_first_rst),
        .in_bit_1                    (grp[0]),
        .in_bit_2                    (grp[1]),
        .in_bit_3                    (grp[2]),
        .in_bit_4                    (grp[3]),
        .in_bit_5                    (grp[4]),
        .in_flag_bitstream           (in_flag_bitstream),
        .in_flag_last                (in_flag_last),
        .in_ready                    (in_ready),
        .out_byte                    (out_byte),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .out_last                    (out_last),
        .fill_level                  (fill_level),
        .err_overflow                (err_overflow),
        .err_count                   (err_count),
        .done                        (done)
    );

    initial clock_gating_flag_first = 1'b0;
    always #5 clock_gating_flag_first = ~clock_gating_flag_first;

    typedef struct {
        logic        rst;
        logic [2:0]  n;
        logic [39:0] b;
        logic        last;
        logic        rdy;
        logic        ev;
        logic [7:0]  eb;
        logic        el;
        logic [4:0]  ef;
        logic        eir, eo, ec, ed;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic [2:0] n, input logic [39:0] b,
                       input logic last, input logic rdy, input logic ev,
                       input logic [7:0] eb, input logic el, input logic [4:0] ef,
                       input logic eir, input logic eo, input logic ec, input logic ed);
        vec_t v;
        v.rst = rst; v.n = n; v.b = b; v.last = last; v.rdy = rdy;
        v.ev = ev; v.eb = eb; v.el = el; v.ef = ef;
        v.eir = eir; v.eo = eo; v.ec = ec; v.ed = ed;
        tv.push_back(v);
    endtask

    task automatic check_outs(input string name, input logic ev, input logic [7:0] eb,
                              input logic el, input logic [4:0] ef, input logic eir,
                              input logic eo, input logic ec, input logic ed);
        logic [17:0] got, exp;
        got = {out_valid, out_byte, out_last, fill_level, in_ready, err_overflow, err_count, done};
        exp = {ev, eb, el, ef, eir, eo, ec, ed};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got v=%b b=%h l=%b f=%0d ir=%b ovf=%b cnt=%b d=%b exp v=%b b=%h l=%b f=%0d ir=%b ovf=%b cnt=%b d=%b",
                     name, out_valid, out_byte, out_last, fill_level, in_ready, err_overflow,
                     err_count, done, ev, eb, el, ef, eir, eo, ec, ed);
        end
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once
    task automatic do_reset();
        clock_gating_flag_first_rst = 1'b1;
        #2;
        check_outs("reset", 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        clock_gating_flag_first_rst = 1'b0;
    endtask

    initial begin
        int sent, rcvd, cyc, k;
        clock_gating_flag_first_rst = 1'b1;
        grp = '0;
        in_flag_bitstream = 3'd0;
        in_flag_last = 1'b0;
        out_ready = 1'b0;

        // rst, n, bytes(in_bit_5..in_bit_1), last, rdy | valid, byte, last, fill, in_ready, ovf, cnt, done
        // Burst of five, drained one per cycle
        add(1, 5, 40'h0504030201, 0, 1,  1, 8'h01, 0, 5,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h02, 0, 4,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h03, 0, 3,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h04, 0, 2,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h05, 0, 1,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  0, 8'h00, 0, 0,  1, 0, 0, 0);
        // Fill to 15 with no consumer, then an oversize group is dropped
        add(0, 5, 40'h1413121110, 0, 0,  1, 8'h10, 0, 5,  1, 0, 0, 0);
        add(0, 5, 40'h2423222120, 0, 0,  1, 8'h10, 0, 10, 1, 0, 0, 0);
        add(0, 5, 40'h3433323130, 0, 0,  1, 8'h10, 0, 15, 0, 0, 0, 0);
        add(0, 2, 40'h4140,       0, 0,  1, 8'h10, 0, 15, 0, 1, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h11, 0, 14, 0, 1, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h12, 0, 13, 0, 1, 0, 0);
        add(0, 0, 40'h0,          0, 0,  1, 8'h12, 0, 13, 0, 1, 0, 0);
        // Last with three bytes; later input is ignored
        add(1, 3, 40'hCCBBAA,     1, 0,  1, 8'hAA, 0, 3,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'hBB, 0, 2,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'hCC, 1, 1,  1, 0, 0, 0);
        add(0, 5, 40'h7574737271, 0, 1,  0, 8'h00, 0, 0,  1, 0, 0, 1);
        add(0, 5, 40'h7574737271, 1, 1,  0, 8'h00, 0, 0,  1, 0, 0, 1);
        // Last on a cycle with no bytes marks the newest stored byte
        add(1, 2, 40'h2211,       0, 0,  1, 8'h11, 0, 2,  1, 0, 0, 0);
        add(0, 0, 40'h0,          1, 0,  1, 8'h11, 0, 2,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  1, 8'h22, 1, 1,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  0, 8'h00, 0, 0,  1, 0, 0, 1);
        // Empty stream
        add(1, 0, 40'h0,          1, 1,  0, 8'h00, 0, 0,  1, 0, 0, 1);
        add(0, 3, 40'h030201,     0, 1,  0, 8'h00, 0, 0,  1, 0, 0, 1);
        // Illegal count, then fill to 9 and reset mid-stream
        add(1, 7, 40'h0504030201, 0, 1,  0, 8'h00, 0, 0,  1, 0, 1, 0);
        add(0, 5, 40'h6564636261, 0, 0,  1, 8'h61, 0, 5,  1, 0, 1, 0);
        add(0, 4, 40'h69686766,   0, 0,  1, 8'h61, 0, 9,  1, 0, 1, 0);
        add(1, 1, 40'h5A,         0, 1,  1, 8'h5A, 0, 1,  1, 0, 0, 0);
        add(0, 0, 40'h0,          0, 1,  0, 8'h00, 0, 0,  1, 0, 0, 0);

        @(posedge clock_gating_flag_first);
        #1;
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            grp               = tv[i].b;
            in_flag_bitstream = tv[i].n;
            in_flag_last      = tv[i].last;
            out_ready         = tv[i].rdy;
            @(posedge clock_gating_flag_first);
            #1;
            check_outs($sformatf("vec%0d", i), tv[i].ev, tv[i].eb, tv[i].el, tv[i].ef,
                       tv[i].eir, tv[i].eo, tv[i].ec, tv[i].ed);
        end

        // Wrap run: 40 incrementing bytes, random group sizes and back-pressure
        do_reset();
        in_flag_last = 1'b0;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 40 && cyc < 2000) begin
            @(negedge clock_gating_flag_first);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                vectors++;
                if (out_byte !== 8'(rcvd)) begin
                    miscompares++;
                    $display("FAIL wrap_byte%0d got %h exp %h", rcvd, out_byte, 8'(rcvd));
                end
                rcvd++;
            end
            in_flag_bitstream = 3'd0;
            grp = '0;
            if (sent < 40 && in_ready) begin
                k = $urandom_range(1, (40 - sent) < 5 ? (40 - sent) : 5);
                for (int j = 0; j < 5; j++)
                    grp[j] = (j < k) ? 8'(sent + j) : 8'hEE;
                in_flag_bitstream = 3'(k);
                sent += k;
            end
        end
        @(posedge clock_gating_flag_first);
        #1;
        out_ready = 1'b0;
        in_flag_bitstream = 3'd0;
        vectors++;
        if (rcvd != 40 || fill_level !== 5'd0 || err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_end got rcvd=%0d fill=%0d ovf=%b exp rcvd=40 fill=0 ovf=0",
                     rcvd, fill_level, err_overflow);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
